adc_sum_sq_ctrl: RTL
====================

Name: adc_sum_sq_ctrl

Overview:
Sequences power measurement of one ADC sample stream: waits for a window sync, squares and accumulates a programmable number of signed samples, then latches a saturated 32-bit sum-of-squares plus status. Sits in the user_clk domain. Its outputs drive the user_data_in of the software-readable sum_sq registers. Its control inputs come from software-written config registers.

Parameters:
DW, 8, ADC sample width (signed two's complement)
MAX_LOG2, 16, largest permitted window exponent (window = 2^len samples)
OUT_W, 32, width of latched result
ACC_W, 2*DW+MAX_LOG2, internal accumulator width (derived, not overridden)

Ports:
user_clk  in  1  block clock
user_rst  in  1  asynchronous reset, active-high
ctrl_en  in  1  enable; level from config register
ctrl_len_log2  in  5  window exponent; values above MAX_LOG2 are clamped to MAX_LOG2
sync_in  in  1  window-start strobe, one cycle
din_valid  in  1  sample qualifier
din  in  DW  signed ADC sample
sum_sq_out  out  OUT_W  latched, saturated sum of squares of the last complete window
sum_sq_valid  out  1  one-cycle pulse when sum_sq_out updates
busy  out  1  high in ARM, ACCUM, DRAIN, LATCH
overflow  out  1  sticky; set when a latched result saturated; cleared only by reset or a ctrl_en 0->1 edge
win_count  out  16  count of completed windows; wraps 0xFFFF->0x0000

Behaviour:
- Reset (async, user_rst=1): state=IDLE; sum_sq_out=0, sum_sq_valid=0, busy=0, overflow=0, win_count=0; accumulator, sample counter and pipeline cleared.
- FSM states: IDLE, ARM, ACCUM, DRAIN, LATCH.
  - IDLE -> ARM: when ctrl_en=1. On entry, latch len = min(ctrl_len_log2, MAX_LOG2), clear accumulator and counter.
  - ARM -> ACCUM: on sync_in=1. If din_valid is also high in that cycle, that sample is the first sample of the window.
  - ACCUM: each cycle with din_valid=1 accepts one sample and increments the counter. After the 2^len-th accepted sample -> DRAIN.
    - sync_in is ignored in ACCUM.
    - din_valid gaps are allowed; the window length counts accepted samples, not cycles.
  - DRAIN: lasts 2 cycles so the pipeline empties; no samples are accepted. Then -> LATCH.
  - LATCH: 1 cycle. Updates sum_sq_out, pulses sum_sq_valid, increments win_count. Then -> ARM if ctrl_en=1 (len re-latched, accumulator cleared), else -> IDLE.
- Pipeline and latency:
  - Stage 1 registers din.
  - Stage 2 registers din*din as unsigned 2*DW bits; the maximum is (-2^(DW-1))^2.
  - Stage 3 adds into the ACC_W accumulator.
  - sum_sq_valid is high exactly 4 cycles after the cycle in which the last sample was accepted.
- Saturation: sum_sq_out = acc if acc < 2^OUT_W, else 2^OUT_W-1; overflow is set in the same cycle. With default parameters acc never exceeds 32 bits.
- ctrl_en falling in ARM, ACCUM or DRAIN: abort to IDLE next cycle. There is no valid pulse, sum_sq_out and win_count hold, and the partial accumulation is discarded.
- ctrl_en falling in the LATCH cycle: the latch completes, then -> IDLE.
- ctrl_len_log2 changes mid-window have no effect until the next ARM entry.
- din_valid outside ACCUM (and outside the ARM sync cycle) is ignored.
- sum_sq_valid is never high for 2 consecutive cycles.

Test Plan:
1. Reset, ctrl_en=1, len=2, sync_in with din=3,-3,5,-128 on consecutive valid cycles -> sum_sq_out=16427 (9+9+25+16384), a single sum_sq_valid 4 cycles after the 4th sample, win_count=1, busy back to 1 (ARM).
2. len=3, din=1 with din_valid toggling 1/0 each cycle -> result 8 only after the 8th valid sample, and valid timing counts from that sample.
3. Abort: len=4, drop ctrl_en after 5 samples -> no sum_sq_valid, sum_sq_out keeps its prior value, state IDLE, busy=0.
4. Boundary: sync_in coincident with the first din_valid sample, and len=0 with din=-1 -> sum_sq_out=1, valid 4 cycles later. Also ctrl_len_log2=31 -> clamps to 16 (65536 samples of din=1 gives 65536).
5. Saturation (build with OUT_W=16): len=2, din=-128 x4 -> sum_sq_out=0xFFFF, overflow=1, and overflow stays set until a ctrl_en 0->1 edge.
6. Assert user_rst mid-ACCUM, asynchronously between clock edges -> all outputs 0 immediately. win_count wrap: preload via 65536 windows of len=0 -> 0x0000.

Source files
------------

// File: rtl/adc_sum_sq_ctrl.sv
// adc_sum_sq_ctrl
// Power measurement sequencer for one ADC sample stream. After a window-start
// strobe it squares and accumulates 2^len signed samples, then latches a
// saturated sum of squares and pulses a one-cycle valid.
//
// Ports
//   user_clk, user_rst   clock, asynchronous active-high reset
//   ctrl_en              enable level; falling edge aborts an open window
//   ctrl_len_log2        window exponent, clamped to MAX_LOG2, sampled on ARM entry
//   sync_in              window-start strobe, honoured only in ARM
//   din_valid, din       signed sample and its qualifier
//   sum_sq_out           saturated sum of squares of the last complete window
//   sum_sq_valid         one-cycle pulse when sum_sq_out updates
//   busy                 high whenever the FSM is out of IDLE
//   overflow             sticky saturation flag, cleared by a ctrl_en rising edge
//   win_count            completed-window counter, wraps
//
// state | meaning
// IDLE  | disabled, waiting for ctrl_en
// ARM   | window length loaded, waiting for sync_in
// ACCUM | accepting samples until the window is full
// DRAIN | two cycles for the square/accumulate pipeline to empty
// LATCH | publish result, bump window count

module adc_sum_sq_ctrl #(
    parameter int DW       = 8,
    parameter int MAX_LOG2 = 16,
    parameter int OUT_W    = 32
) (
    input  logic                 user_clk,
    input  logic                 user_rst,
    input  logic                 ctrl_en,
    input  logic [4:0]           ctrl_len_log2,
    input  logic                 sync_in,
    input  logic                 din_valid,
    input  logic signed [DW-1:0] din,
    output logic [OUT_W-1:0]     sum_sq_out,
    output logic                 sum_sq_valid,
    output logic                 busy,
    output logic                 overflow,
    output logic [15:0]          win_count
);

    localparam int ACC_W = 2*DW + MAX_LOG2;

    typedef enum logic [2:0] {IDLE, ARM, ACCUM, DRAIN, LATCH} state_t;

    state_t                state_q, state_d;
    logic [MAX_LOG2-1:0]   cnt_q, cnt_d;
    logic                  drain_q;
    logic                  en_q;
    logic signed [DW-1:0]  s1_q;
    logic                  s1_vld_q;
    logic [2*DW-1:0]       s2_q;
    logic                  s2_vld_q;
    logic [ACC_W-1:0]      acc_q;
    logic [OUT_W-1:0]      sum_q;
    logic                  valid_q;
    logic                  ovf_q;
    logic [15:0]           win_q;

    logic [4:0]            len_c;
    logic [MAX_LOG2-1:0]   cnt_load;
    logic                  accept;
    logic                  last;
    logic                  arm_entry;
    logic                  clr;
    logic signed [2*DW-1:0] prod;
    logic                  sat;
    logic [OUT_W-1:0]      res;

    assign len_c = (ctrl_len_log2 > 5'(MAX_LOG2)) ? 5'(MAX_LOG2) : ctrl_len_log2;
    // Down-counter holds samples still needed minus one; for len=MAX_LOG2 the
    // shift wraps to zero and the subtraction yields all ones, which is exact.
    assign cnt_load = (MAX_LOG2'(1) << len_c) - MAX_LOG2'(1);

    assign accept    = ctrl_en && din_valid &&
                       ((state_q == ACCUM) || ((state_q == ARM) && sync_in));
    assign last      = accept && (cnt_q == '0);
    assign arm_entry = (state_d == ARM) && (state_q != ARM);
    // Any fresh window or abort throws away whatever is in flight.
    assign clr       = arm_entry || ((state_d == IDLE) && (state_q != IDLE));
    assign prod      = s1_q * s1_q;

    generate
        if (ACC_W > OUT_W) begin : g_sat
            assign sat = |acc_q[ACC_W-1:OUT_W];
            assign res = sat ? {OUT_W{1'b1}} : acc_q[OUT_W-1:0];
        end else begin : g_nosat
            assign sat = 1'b0;
            assign res = OUT_W'(acc_q);
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ctrl_en) state_d = ARM;
            ARM: begin
                if (!ctrl_en)    state_d = IDLE;
                else if (sync_in) state_d = last ? DRAIN : ACCUM;
            end
            ACCUM: begin
                if (!ctrl_en)  state_d = IDLE;
                else if (last) state_d = DRAIN;
            end
            DRAIN: begin
                if (!ctrl_en)     state_d = IDLE;
                else if (!drain_q) state_d = LATCH;
            end
            LATCH:   state_d = ctrl_en ? ARM : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (arm_entry)
            cnt_d = cnt_load;
        else if (accept && !last)
            cnt_d = cnt_q - MAX_LOG2'(1);
    end

    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            // High only in the first DRAIN cycle.
            drain_q <= (state_q != DRAIN);
        end
    end

    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            en_q     <= 1'b0;
            s1_q     <= '0;
            s1_vld_q <= 1'b0;
            s2_q     <= '0;
            s2_vld_q <= 1'b0;
            acc_q    <= '0;
        end else begin
            en_q <= ctrl_en;
            if (clr) begin
                s1_vld_q <= 1'b0;
                s2_vld_q <= 1'b0;
                acc_q    <= '0;
            end else begin
                s1_vld_q <= accept;
                if (accept) s1_q <= din;
                s2_vld_q <= s1_vld_q;
                if (s1_vld_q) s2_q <= unsigned'(prod);
                if (s2_vld_q) acc_q <= acc_q + ACC_W'(s2_q);
            end
        end
    end

    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            sum_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            win_q   <= '0;
        end else begin
            valid_q <= (state_q == LATCH);
            if (state_q == LATCH) begin
                sum_q <= res;
                win_q <= win_q + 16'd1;
            end
            if ((state_q == LATCH) && sat)
                ovf_q <= 1'b1;
            else if (ctrl_en && !en_q)
                ovf_q <= 1'b0;
        end
    end

    assign sum_sq_out   = sum_q;
    assign sum_sq_valid = valid_q;
    assign busy         = (state_q != IDLE);
    assign overflow     = ovf_q;
    assign win_count    = win_q;

endmodule
